// File: rtl/msk_frame_sync.sv
// msk_frame_sync - frame synchronizer for the MSK demodulator bit stream.
//
// Hunts for SYNC_WORD in the serial stream, confirms it at the frame period
// (VERIFY), then flywheels through isolated sync errors (LOCK). Payload bits
// between sync words are packed MSB first into bytes.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   bit_sync     one-clk bit strobe; din is sampled when high
//   din          demodulated data bit
//   byte_out     assembled payload byte (holds between byte_valid pulses)
//   byte_valid   one-clk pulse, byte_out valid
//   frame_start  one-clk pulse at each accepted or flywheeled frame boundary
//   lock         high while in LOCK
//   state        00 SEARCH, 01 VERIFY, 10 LOCK
module msk_frame_sync #(
  parameter logic [15:0] SYNC_WORD     = 16'hEB90,
  parameter int          PAYLOAD_BYTES = 8,
  parameter int          MAX_ERR       = 1,
  parameter int          LOCK_CNT      = 2,
  parameter int          MISS_CNT      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_sync,
  input  logic       din,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       lock,
  output logic [1:0] state
);

  localparam int PAY_BITS = 8 * PAYLOAD_BYTES;
  localparam int F        = 16 + PAY_BITS;
  localparam int BW       = $clog2(F);

  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] MISS_C = 8'(MISS_CNT);
  localparam logic [4:0] ERR_C  = 5'(MAX_ERR);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } st_t;

  st_t st;

  // Only the 15 most recent bits are stored: the oldest bit of the 16-bit
  // window is shifted out before every comparison, so it is never needed.
  logic [14:0]   sr;
  logic [15:0]   nsr;
  logic [15:0]   diff;
  logic [4:0]    err;
  logic [BW-1:0] bcnt;
  logic [BW:0]   pos;      // frame position of the incoming bit
  logic          is_bnd;
  logic          in_pay;
  logic          err_ok;
  logic [7:0]    bsr;
  logic [7:0]    hit, miss;
  logic [7:0]    hit_inc, miss_inc;

  assign state = st;

  always_comb begin
    nsr  = {sr, din};
    diff = nsr ^ SYNC_WORD;
    err  = '0;
    for (int i = 0; i < 16; i++) err = err + 5'(diff[i]);
    err_ok   = (err <= ERR_C);
    pos      = {1'b0, bcnt} + (BW+1)'(1);
    is_bnd   = (bcnt == BW'(F - 1));
    in_pay   = !is_bnd && (pos <= (BW+1)'(PAY_BITS));
    hit_inc  = (hit  == 8'hFF) ? hit  : hit  + 8'd1;
    miss_inc = (miss == 8'hFF) ? miss : miss + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= SEARCH;
      sr          <= '0;
      bcnt        <= '0;
      bsr         <= '0;
      hit         <= '0;
      miss        <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      lock        <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      if (bit_sync) begin
        // sr is kept across state changes so an overlapping sync word can be
        // found on the bit right after a failed boundary.
        sr <= nsr[14:0];
        case (st)
          SEARCH: begin
            if (err == 5'd0) begin
              st          <= VERIFY;
              hit         <= '0;
              bcnt        <= '0;
              bsr         <= '0;
              frame_start <= 1'b1;
            end
          end
          VERIFY, LOCKED: begin
            if (is_bnd) begin
              bcnt <= '0;
              bsr  <= '0;
              if (st == VERIFY) begin
                if (err_ok) begin
                  frame_start <= 1'b1;
                  hit         <= hit_inc;
                  if (hit_inc >= LOCK_C) begin
                    st   <= LOCKED;
                    lock <= 1'b1;
                    miss <= '0;
                  end
                end else begin
                  st <= SEARCH;
                end
              end else begin
                if (err_ok) begin
                  miss        <= '0;
                  frame_start <= 1'b1;
                end else if (miss_inc >= MISS_C) begin
                  // Lock lost: no flywheel pulse on the failing boundary.
                  miss <= miss_inc;
                  st   <= SEARCH;
                  lock <= 1'b0;
                end else begin
                  miss        <= miss_inc;
                  frame_start <= 1'b1;
                end
              end
            end else begin
              bcnt <= pos[BW-1:0];
              if (in_pay) begin
                bsr <= {bsr[6:0], din};
                if (pos[2:0] == 3'b000) begin
                  byte_out   <= {bsr[6:0], din};
                  byte_valid <= 1'b1;
                end
              end
            end
          end
          default: begin
            st   <= SEARCH;
            lock <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msk_frame_sync.sv
// tb_msk_frame_sync - scoreboard bench for msk_frame_sync.
// Expected byte/frame_start events are queued as stimulus is driven; a
// negedge monitor pops and compares every pulse the DUT produces.
module tb_msk_frame_sync;

  localparam logic [15:0] SYNC = 16'hEB90;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_sync = 1'b0;
  logic       din = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid, frame_start, lock;
  logic [1:0] state;

  typedef struct packed {
    logic       fs;
    logic [7:0] b;
  } ev_t;

  ev_t         sbq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] shadow   = '0;
  logic [7:0]  pay[8];

  msk_frame_sync dut (
    .clk(clk), .rst(rst), .bit_sync(bit_sync), .din(din),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
    .lock(lock), .state(state)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && (byte_valid || frame_start)) begin
      ev_t e;
      n_assert++;
      if (byte_valid && frame_start) begin
        n_fail++;
        $display("FAIL pulse_overlap: byte_valid and frame_start both high");
      end else if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: fs=%0b bv=%0b byte=%02h, nothing expected",
                 frame_start, byte_valid, byte_out);
      end else begin
        e = sbq.pop_front();
        if (frame_start !== e.fs || (!e.fs && byte_out !== e.b)) begin
          n_fail++;
          $display("FAIL sb_event: got fs=%0b byte=%02h, expected fs=%0b byte=%02h",
                   frame_start, byte_out, e.fs, e.b);
        end
      end
    end
  end

  task automatic exp_fs();
    ev_t e;
    e.fs = 1'b1; e.b = 8'h00;
    sbq.push_back(e);
  endtask

  task automatic exp_byte(input logic [7:0] b);
    ev_t e;
    e.fs = 1'b0; e.b = b;
    sbq.push_back(e);
  endtask

  // Random idle gap, then one bit; returns 1 time unit after the sampling edge.
  task automatic send_bit(input logic b);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
    din = b; bit_sync = 1'b1;
    shadow = {shadow[14:0], b};
    @(posedge clk); #1;
    bit_sync = 1'b0; din = 1'($urandom);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Random bits that never complete the sync word.
  task automatic send_rand(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom);
      if ({shadow[14:0], b} == SYNC) b = ~b;
      send_bit(b);
    end
  endtask

  // Payload (bytes expected) followed by a boundary word.
  task automatic send_frame(input logic [15:0] sw, input bit fs_exp);
    for (int i = 0; i < 8; i++) exp_byte(pay[i]);
    for (int i = 0; i < 8; i++) send_byte(pay[i]);
    if (fs_exp) exp_fs();
    send_word(sw);
  endtask

  task automatic drain(input string name);
    @(negedge clk); #1;
    n_assert++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: %0d expected events never seen, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_sync = 1'($urandom); din = 1'($urandom);
      @(posedge clk); #1;
      n_assert++;
      if ({byte_out, byte_valid, frame_start, lock, state} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %013b, expected 0",
                 {byte_out, byte_valid, frame_start, lock, state});
      end
    end
    bit_sync = 1'b0;
    rst = 1'b1;
    shadow = '0;
    send_rand(24);
    n_assert++;
    if (state !== 2'b00 || lock !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: state=%b lock=%b, expected 00/0", state, lock);
    end
    drain("reset");
  endtask

  task automatic test_acquire();
    send_rand(37);
    exp_fs();
    send_word(SYNC);
    n_assert++;
    if (frame_start !== 1'b1 || state !== 2'b01) begin
      n_fail++;
      $display("FAIL acquire: fs=%b state=%b, expected 1/01", frame_start, state);
    end
    drain("acquire");
  endtask

  task automatic test_lock();
    send_frame(SYNC, 1);
    n_assert++;
    if (state !== 2'b01 || lock !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_hit1: state=%b lock=%b, expected 01/0", state, lock);
    end
    send_frame(SYNC, 1);
    n_assert++;
    if (state !== 2'b10 || lock !== 1'b1 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_enter: state=%b lock=%b fs=%b, expected 10/1/1", state, lock, frame_start);
    end
    send_frame(SYNC, 1);
    n_assert++;
    if (state !== 2'b10 || lock !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_hold: state=%b lock=%b, expected 10/1", state, lock);
    end
    drain("lock");
  endtask

  task automatic test_tolerance();
    logic [15:0] words[4];
    words = '{16'hAAAA, 16'hEB91, 16'hAAAA, 16'hAAAA};
    for (int k = 0; k < 3; k++) begin
      send_frame(words[k], 1);
      n_assert++;
      if (lock !== 1'b1 || state !== 2'b10 || frame_start !== 1'b1) begin
        n_fail++;
        $display("FAIL tol_flywheel%0d: lock=%b state=%b fs=%b, expected 1/10/1",
                 k, lock, state, frame_start);
      end
    end
    send_frame(words[3], 0);
    n_assert++;
    if (lock !== 1'b0 || state !== 2'b00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL tol_drop: lock=%b state=%b fs=%b, expected 0/00/0", lock, state, frame_start);
    end
    drain("tolerance");
  endtask

  task automatic test_false_sync();
    exp_fs();
    send_word(SYNC);
    pay = '{8'hEB, 8'h90, 8'h55, 8'hEB, 8'h90, 8'h01, 8'hFF, 8'h00};
    send_frame(SYNC, 1);
    n_assert++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL false_payload: state=%b, expected 01", state);
    end
    send_frame(16'hEB93, 0);
    n_assert++;
    if (state !== 2'b00 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL false_2err: state=%b fs=%b, expected 00/0", state, frame_start);
    end
    drain("false_sync");
  endtask

  task automatic test_midreset();
    pay = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    exp_fs();
    send_word(SYNC);
    exp_byte(8'h12);
    send_byte(8'h12);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    // Fourth bit of 0x34: reset lands mid-cycle, before the sampling edge.
    din = 1'b1; bit_sync = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_assert++;
    if ({byte_out, byte_valid, frame_start, lock, state} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %013b, expected 0",
               {byte_out, byte_valid, frame_start, lock, state});
    end
    bit_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    shadow = '0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_rand(20);
    n_assert++;
    if (state !== 2'b00) begin
      n_fail++;
      $display("FAIL midreset_idle: state=%b, expected 00", state);
    end
    exp_fs();
    send_word(SYNC);
    send_frame(SYNC, 1);
    n_assert++;
    if (state !== 2'b01 || lock !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_reacq: state=%b lock=%b, expected 01/0", state, lock);
    end
    drain("midreset");
  endtask

  initial begin
    pay = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    #2;
    test_reset();
    test_acquire();
    test_lock();
    test_tolerance();
    test_false_sync();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/msk_frame_sync.md
Name: msk_frame_sync

Overview:
- Frame synchronizer directly downstream of the MSK demodulator output stage.
- Consumes the differentially decoded serial bit stream (`din`, qualified by the `bit_sync` pulse) and searches for a fixed sync word.
- Confirms the sync word at the expected frame period and flywheels through isolated sync errors.
- Emits payload bytes, a frame-start pulse and a lock flag to the downstream data sink.

Parameters:
- SYNC_WORD, 16'hEB90, frame sync pattern; first bit received is the MSB.
- PAYLOAD_BYTES, 8, payload bytes following each sync word (range 1..255).
- MAX_ERR, 1, maximum Hamming distance accepted at an expected sync position in VERIFY/LOCK.
- LOCK_CNT, 2, consecutive confirmed sync words in VERIFY needed to enter LOCK.
- MISS_CNT, 2, consecutive failed sync words in LOCK needed to drop to SEARCH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- bit_sync  in  1  bit strobe, one clk wide; each clk it is high carries one bit.
- din  in  1  demodulated data bit, valid when bit_sync=1.
- byte_out  out  8  assembled payload byte, MSB first.
- byte_valid  out  1  one-clk pulse, byte_out valid.
- frame_start  out  1  one-clk pulse at each accepted or flywheeled frame boundary.
- lock  out  1  high while state=LOCK.
- state  out  2  00 SEARCH, 01 VERIFY, 10 LOCK (debug).

Behaviour:
- rst=0: all outputs 0, shift register 0, all counters 0, state SEARCH; takes effect immediately regardless of clk.
- All processing happens only on clk edges with bit_sync=1; when bit_sync=0, state and outputs hold, except pulses, which return to 0.
- On each bit: sr <= {sr[14:0], din}. All comparisons use the updated value nsr = {sr[14:0], din}.
- Error count err = popcount(nsr ^ SYNC_WORD), 5 bits wide, combinational.
- Frame length F = 16 + 8*PAYLOAD_BYTES bits. Bit counter bcnt runs 0..F-1 and is cleared to 0 at each accepted or flywheeled boundary. Payload occupies bcnt 1..8*PAYLOAD_BYTES. The boundary check occurs at bcnt = F-1.
- SEARCH:
  - Compares on every bit.
  - err==0 (exact match only) -> VERIFY, hit=0, bcnt=0, frame_start pulse.
  - No byte output in SEARCH.
- VERIFY:
  - Payload bits shift into a byte register; every 8th payload bit raises byte_valid.
  - At bcnt=F-1 with err<=MAX_ERR: hit++ and frame_start pulses. If hit reaches LOCK_CNT -> LOCK, miss=0.
  - At bcnt=F-1 with err>MAX_ERR: -> SEARCH, no frame_start.
  - Sync patterns at any other bit position are ignored.
- LOCK:
  - Bytes are output exactly as in VERIFY.
  - At bcnt=F-1, frame_start always pulses (flywheel) and bcnt restarts.
  - err<=MAX_ERR -> miss=0.
  - err>MAX_ERR -> miss++. If miss reaches MISS_CNT -> SEARCH, lock=0, and frame_start is suppressed on that bit.
- Latency: every output (byte_valid, frame_start, lock, state) is registered and changes on the same clk edge that samples the relevant bit. It is visible in the cycle after the bit_sync pulse.
- byte_valid and frame_start never pulse on the same bit.
- lock rises on the same edge as the frame_start of the LOCK_CNT-th confirmation, and falls on the edge of the MISS_CNT-th miss.
- Leaving VERIFY/LOCK for SEARCH discards any partial byte.
- Entering SEARCH does not clear sr, so a sync word overlapping the failed position can be detected on the next bit.
- Counters hit and miss saturate; neither can wrap.

Test Plan:
1. Reset: hold rst=0 with random din/bit_sync -> all outputs 0, state=00. Release rst -> no pulses until a sync word arrives.
2. Acquire: 37 random bits, then EB90, then payload 12 34 56 78 9A BC DE F0 -> frame_start pulse one clk after the last sync bit, state=01; byte_valid ×8 with byte_out 12..F0 in order.
3. Lock: three consecutive clean 80-bit frames -> frame_start at each boundary; state 01 -> 01 (hit=1) -> 10; lock=1 on the third frame_start.
4. Tolerance: in LOCK send EB91 (1 error) -> lock stays 1, miss=0. Send AAAA once -> lock stays 1 and frame_start still pulses. Send AAAA a second consecutive time -> lock=0, state=00, no frame_start.
5. False sync: in VERIFY, payload bytes EB 90 -> no frame_start and bytes output normally. In VERIFY, boundary word with 2 errors (EB93) -> state=00.
6. Mid-operation reset: pull rst low during the 4th payload bit of a byte -> outputs clear asynchronously. After release, the partial byte is never emitted and the block re-acquires on the next EB90.
